// File: rtl/axi_master_pkg.sv
// Shared types and default configuration for the axi_master block.
package axi_master_pkg;

    localparam int unsigned DEF_ADDR_W      = 4;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 16;

    // Transaction sequencer states: one read path, one write path.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WDATA = 3'd4,
        WRESP = 3'd5
    } state_t;

endpackage

// File: rtl/axi_master.sv
// Single-outstanding AXI-style master: one read or one write at a time.
// Optional watchdog enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_master
    import axi_master_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    // user side
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address_to_read,
    input  logic [ADDR_W-1:0] address_to_write,
    input  logic [DATA_W-1:0] data_to_write,
    // read address channel
    output logic [ADDR_W-1:0] read_address,
    output logic              AR_VALID,
    input  logic              AR_READY,
    // read data channel
    input  logic [DATA_W-1:0] data_read,
    input  logic              R_VALID,
    output logic              R_READY,
    // write address channel
    output logic [ADDR_W-1:0] write_address,
    output logic              AW_VALID,
    input  logic              AW_READY,
    // write data channel
    output logic [DATA_W-1:0] data_write,
    output logic              W_VALID,
    input  logic              W_READY,
    // write response channel
    input  logic              B_VALID,
    output logic              B_READY,
`ifdef AXI_MASTER_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic [DATA_W-1:0] data_being_read
);

    state_t state;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;
    logic             hs_c;

    // Handshake completing on the current edge for whichever channel is active.
    always_comb begin
        hs_c = 1'b0;
        case (state)
            RADDR:   hs_c = AR_READY;
            RDATA:   hs_c = R_VALID;
            WADDR:   hs_c = AW_READY;
            WDATA:   hs_c = W_READY;
            WRESP:   hs_c = B_VALID;
            default: hs_c = 1'b0;
        endcase
    end
`else
    // The limit has no effect when the watchdog is not built.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^(32'(TIMEOUT_CYC));
`endif

    // Sequencer: state plus every channel output, all registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            read_address    <= '0;
            write_address   <= '0;
            data_write      <= '0;
            data_being_read <= '0;
            AR_VALID        <= 1'b0;
            R_READY         <= 1'b0;
            AW_VALID        <= 1'b0;
            W_VALID         <= 1'b0;
            B_READY         <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            cnt             <= '0;
            timeout_err     <= 1'b0;
`endif
        end else begin
`ifdef AXI_MASTER_TIMEOUT_EN
            timeout_err <= 1'b0;
            if (state == IDLE || hs_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
`endif
            case (state)
                IDLE: begin
                    // read has priority; a simultaneous write is dropped
                    if (read) begin
                        read_address <= address_to_read;
                        AR_VALID     <= 1'b1;
                        state        <= RADDR;
                    end else if (write) begin
                        write_address <= address_to_write;
                        AW_VALID      <= 1'b1;
                        state         <= WADDR;
                    end
                end
                RADDR: begin
                    if (AR_READY) begin
                        AR_VALID <= 1'b0;
                        R_READY  <= 1'b1;
                        state    <= RDATA;
                    end
                end
                RDATA: begin
                    if (R_VALID) begin
                        data_being_read <= data_read;
                        R_READY         <= 1'b0;
                        state           <= IDLE;
                    end
                end
                WADDR: begin
                    // payload is sampled at the address handshake, not at the strobe
                    if (AW_READY) begin
                        data_write <= data_to_write;
                        AW_VALID   <= 1'b0;
                        W_VALID    <= 1'b1;
                        state      <= WDATA;
                    end
                end
                WDATA: begin
                    if (W_READY) begin
                        W_VALID <= 1'b0;
                        B_READY <= 1'b1;
                        state   <= WRESP;
                    end
                end
                WRESP: begin
                    if (B_VALID) begin
                        B_READY <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    AR_VALID <= 1'b0;
                    R_READY  <= 1'b0;
                    AW_VALID <= 1'b0;
                    W_VALID  <= 1'b0;
                    B_READY  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
`ifdef AXI_MASTER_TIMEOUT_EN
            // a stalled channel is abandoned once it has waited the full limit
            if (state != IDLE && !hs_c && cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                AR_VALID    <= 1'b0;
                R_READY     <= 1'b0;
                AW_VALID    <= 1'b0;
                W_VALID     <= 1'b0;
                B_READY     <= 1'b0;
                cnt         <= '0;
                timeout_err <= 1'b1;
                state       <= IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi_master.sv
// Bench for axi_master with an inline 16x8 memory slave and a memory reference model.
// Build with AXI_MASTER_TIMEOUT_EN defined to also exercise the watchdog.
module tb_axi_master;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] address_to_read = '0;
    logic [AW-1:0] address_to_write = '0;
    logic [DW-1:0] data_to_write = '0;
    logic [AW-1:0] read_address;
    logic          AR_VALID;
    logic          AR_READY = 1'b0;
    logic [DW-1:0] data_read = '0;
    logic          R_VALID = 1'b0;
    logic          R_READY;
    logic [AW-1:0] write_address;
    logic          AW_VALID;
    logic          AW_READY = 1'b0;
    logic [DW-1:0] data_write;
    logic          W_VALID;
    logic          W_READY = 1'b0;
    logic          B_VALID = 1'b0;
    logic          B_READY;
    logic [DW-1:0] data_being_read;
`ifdef AXI_MASTER_TIMEOUT_EN
    logic          timeout_err;
    int            te_cnt = 0;
    int            te_edge = 0;
`endif

    int total = 0;
    int bad = 0;

    // slave state and handshake bookkeeping
    logic [DW-1:0] smem [16];
    logic [DW-1:0] model_mem [16];
    logic [AW-1:0] rd_addr = '0;
    logic [AW-1:0] wr_addr = '0;
    bit            rd_pend = 1'b0;
    bit            b_pend = 1'b0;
    int            ar_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    int            cyc = 0;
    int            ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, awv_cnt = 0;
    int            r_cyc = 0, w_cyc = 0, b_cyc = 0;
    logic [DW-1:0] exp_wdata = '0;

    axi_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .read(read), .write(write),
        .address_to_read(address_to_read), .address_to_write(address_to_write),
        .data_to_write(data_to_write),
        .read_address(read_address), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .data_read(data_read), .R_VALID(R_VALID), .R_READY(R_READY),
        .write_address(write_address), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .data_write(data_write), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_READY(B_READY),
`ifdef AXI_MASTER_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .data_being_read(data_being_read)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave outputs change on the falling edge, away from the DUT sampling edge.
    initial begin : slave_drive
        forever begin
            @(negedge clk);
            if (!rst) begin
                AR_READY = 1'b0; R_VALID = 1'b0; AW_READY = 1'b0;
                W_READY = 1'b0; B_VALID = 1'b0;
                ar_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
            end else begin
                AR_READY = AR_VALID && ar_wait == 0;
                if (AR_VALID && ar_wait > 0) ar_wait--;
                AW_READY = AW_VALID && aw_wait == 0;
                if (AW_VALID && aw_wait > 0) aw_wait--;
                W_READY = W_VALID && w_wait == 0;
                if (W_VALID && w_wait > 0) w_wait--;
                R_VALID = rd_pend;
                data_read = rd_pend ? smem[rd_addr] : DW'($urandom);
                B_VALID = b_pend && b_wait == 0;
                if (b_pend && b_wait > 0) b_wait--;
            end
        end
    end

    // Handshake observer on the rising edge: slave memory, counters, protocol checks.
    initial begin : slave_mon
        logic          p_rst = 1'b0, p_arv = 1'b0, p_arr = 1'b0, p_awv = 1'b0, p_awr = 1'b0;
        logic          p_wv = 1'b0, p_wr = 1'b0, p_rhs = 1'b0;
        logic [AW-1:0] p_ra = '0, p_wa = '0;
        logic [DW-1:0] p_wd = '0, p_dbr = '0, p_dr = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                rd_pend = 1'b0;
                b_pend = 1'b0;
                for (int i = 0; i < 16; i++) smem[i] = '0;
            end else begin
                if (AR_VALID && AR_READY) begin ar_cnt++; rd_addr = read_address; rd_pend = 1'b1; end
                if (R_VALID && R_READY) begin r_cnt++; r_cyc = cyc; rd_pend = 1'b0; end
                if (AW_VALID && AW_READY) begin aw_cnt++; wr_addr = write_address; end
                if (W_VALID && W_READY) begin w_cnt++; w_cyc = cyc; smem[wr_addr] = data_write; b_pend = 1'b1; end
                if (B_VALID && B_READY) begin b_cnt++; b_cyc = cyc; b_pend = 1'b0; end
                if (W_VALID) chk("w_payload", 32'(data_write), 32'(exp_wdata));
                if (p_rst) begin
                    if (p_arv && !p_arr) chk("ar_hold", 32'({AR_VALID, read_address}), 32'({1'b1, p_ra}));
                    if (p_awv && !p_awr) chk("aw_hold", 32'({AW_VALID, write_address}), 32'({1'b1, p_wa}));
                    if (p_wv && !p_wr) chk("w_hold", 32'({W_VALID, data_write}), 32'({1'b1, p_wd}));
                    if (data_being_read !== p_dbr) chk("dbr_change_needs_r", 32'(p_rhs), 32'd1);
                    if (p_rhs) chk("dbr_value", 32'(data_being_read), 32'(p_dr));
                end
            end
            if (AW_VALID) awv_cnt++;
`ifdef AXI_MASTER_TIMEOUT_EN
            if (timeout_err === 1'b1) begin te_cnt++; te_edge = cyc - 1; end
`endif
            p_rst = rst; p_arv = AR_VALID; p_arr = AR_READY; p_ra = read_address;
            p_awv = AW_VALID; p_awr = AW_READY; p_wa = write_address;
            p_wv = W_VALID; p_wr = W_READY; p_wd = data_write;
            p_dbr = data_being_read; p_rhs = R_VALID && R_READY; p_dr = data_read;
        end
    end

    // mode 0: plain read; 1: write strobe together with read; 2: write strobe one cycle later
    task automatic do_read(input logic [AW-1:0] addr, input int arw, input int mode);
        int n0, awv0, edge_n, n;
        n0 = r_cnt;
        awv0 = awv_cnt;
        @(negedge clk);
        ar_wait = arw;
        read = 1'b1;
        address_to_read = addr;
        if (mode == 1) begin write = 1'b1; address_to_write = ~addr; end
        edge_n = cyc + 1;
        @(negedge clk);
        read = 1'b0;
        write = (mode == 2);
        address_to_read = ~addr;
        address_to_write = ~addr;
        chk("ar_valid_rise", 32'(AR_VALID), 32'd1);
        chk("read_address", 32'(read_address), 32'(addr));
        @(negedge clk);
        write = 1'b0;
        n = 0;
        while (r_cnt == n0 && n < 200) begin @(negedge clk); n++; end
        chk("read_done", 32'(r_cnt - n0), 32'd1);
        chk("read_data", 32'(data_being_read), 32'(model_mem[addr]));
        chk("read_latency", 32'(r_cyc), 32'(edge_n + 2 + arw));
        chk("no_aw_during_read", 32'(awv_cnt - awv0), 32'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input int aww, input int ww, input int bw);
        int n0, a0, edge_n, n;
        n0 = b_cnt;
        a0 = aw_cnt;
        @(negedge clk);
        aw_wait = aww; w_wait = ww; b_wait = bw;
        write = 1'b1;
        address_to_write = addr;
        data_to_write = ~data;
        exp_wdata = data;
        edge_n = cyc + 1;
        @(negedge clk);
        write = 1'b0;
        data_to_write = data;
        address_to_write = ~addr;
        chk("aw_valid_rise", 32'(AW_VALID), 32'd1);
        chk("write_address", 32'(write_address), 32'(addr));
        n = 0;
        while (aw_cnt == a0 && n < 200) begin @(negedge clk); n++; end
        data_to_write = DW'($urandom);
        n = 0;
        while (b_cnt == n0 && n < 200) begin @(negedge clk); n++; end
        chk("write_done", 32'(b_cnt - n0), 32'd1);
        chk("write_latency", 32'(b_cyc), 32'(edge_n + 3 + aww + ww + bw));
        model_mem[addr] = data;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int n, n0, b0;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_ar_valid", 32'(AR_VALID), 32'd0);
        chk("rst_r_ready", 32'(R_READY), 32'd0);
        chk("rst_aw_valid", 32'(AW_VALID), 32'd0);
        chk("rst_w_valid", 32'(W_VALID), 32'd0);
        chk("rst_b_ready", 32'(B_READY), 32'd0);
        chk("rst_read_address", 32'(read_address), 32'd0);
        chk("rst_write_address", 32'(write_address), 32'd0);
        chk("rst_data_write", 32'(data_write), 32'd0);
        chk("rst_data_being_read", 32'(data_being_read), 32'd0);
`ifdef AXI_MASTER_TIMEOUT_EN
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
`endif
        rst = 1'b1;

        // directed: fresh read, write, read back, stalled read, strobe collisions
        do_read(4'h5, 0, 0);
        do_write(4'h5, 8'hAA, 0, 0, 0);
        do_read(4'h5, 0, 0);
        do_write(4'h3, 8'h3C, 1, 2, 1);
        do_read(4'h3, 5, 0);
        do_read(4'h5, 0, 1);
        do_read(4'h3, 2, 2);

        // randomized mix against the memory model
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_read(AW'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end else begin
                do_write(AW'($urandom), DW'($urandom), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
        end

        // reset in the middle of the write-data phase
        n0 = w_cnt;
        b0 = b_cnt;
        @(negedge clk);
        aw_wait = 0; w_wait = 6; b_wait = 0;
        write = 1'b1;
        address_to_write = 4'h9;
        data_to_write = 8'h5C;
        exp_wdata = 8'h5C;
        @(negedge clk);
        write = 1'b0;
        n = 0;
        while (W_VALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("reached_wdata", 32'(W_VALID), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_ar_valid", 32'(AR_VALID), 32'd0);
        chk("abort_r_ready", 32'(R_READY), 32'd0);
        chk("abort_aw_valid", 32'(AW_VALID), 32'd0);
        chk("abort_w_valid", 32'(W_VALID), 32'd0);
        chk("abort_b_ready", 32'(B_READY), 32'd0);
        chk("abort_addresses", 32'({read_address, write_address}), 32'd0);
        chk("abort_data", 32'({data_write, data_being_read}), 32'd0);
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_w_after_abort", 32'(w_cnt - n0), 32'd0);
        chk("no_b_after_abort", 32'(b_cnt - b0), 32'd0);
        chk("idle_after_abort", 32'({W_VALID, B_READY, AW_VALID}), 32'd0);
        do_read(4'h9, 0, 0);
        do_read(4'h5, 1, 0);

`ifdef AXI_MASTER_TIMEOUT_EN
        // write response never arrives
        n0 = te_cnt;
        @(negedge clk);
        aw_wait = 0; w_wait = 0; b_wait = 1000000;
        write = 1'b1;
        address_to_write = 4'hC;
        data_to_write = 8'h77;
        exp_wdata = 8'h77;
        @(negedge clk);
        write = 1'b0;
        n = 0;
        while (te_cnt == n0 && n < 100) begin @(negedge clk); n++; end
        chk("timeout_seen", 32'(te_cnt - n0), 32'd1);
        chk("timeout_edge", 32'(te_edge), 32'(w_cyc + int'(TO)));
        repeat (4) @(negedge clk);
        chk("timeout_single_pulse", 32'(te_cnt - n0), 32'd1);
        chk("b_ready_after_timeout", 32'(B_READY), 32'd0);
        b_pend = 1'b0;
        b_wait = 0;
        model_mem[12] = 8'h77;
        do_read(4'hC, 0, 0);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
